// File: rtl/regfile_pkg.sv
// Shared sizing and one-hot decode helpers for the register-file write path.
// Declarations only: no state, no latency, no flow control.
package regfile_pkg;

  localparam int DEF_ADDR_W    = 5;
  localparam int ONEHOT_MAX_AW = 8;
  localparam int ONEHOT_MAX_N  = 1 << ONEHOT_MAX_AW;

  function automatic int reg_count(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Decodes at the widest supported address; callers truncate to their own register count.
  function automatic logic [ONEHOT_MAX_N-1:0] onehot(input logic [ONEHOT_MAX_AW-1:0] addr);
    logic [ONEHOT_MAX_N-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/onehot_decd.sv
// Enable-gated address to one-hot decoder with optional masking of entry 0.
// Purely combinational; no backpressure.
module onehot_decd
  import regfile_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter bit ZERO_MASK = 1'b1,
  localparam int NREG     = reg_count(ADDR_W)
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [NREG-1:0]   dec
);

  always_comb begin
    dec = '0;
    if (en) begin
      dec = NREG'(onehot(ONEHOT_MAX_AW'(addr)));
    end
    if (ZERO_MASK) begin
      dec[0] = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// Register-file write control: per-register write enables, port-B select, collision flag, pending scoreboard.
// Decode outputs take 1 cycle when OUT_REG=1, else combinational; rd_stall is combinational from pending; no backpressure.
module regfile_wr_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter bit ZERO_RO = 1'b1,
  parameter bit OUT_REG = 1'b1,
  localparam int NREG   = reg_count(ADDR_W)
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              wr_en_a,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [NREG-1:0]   we_onehot,
  output logic [NREG-1:0]   sel_b,
  output logic              collision,
  output logic [NREG-1:0]   pending,
  output logic              rd_stall
);

  logic [NREG-1:0] dec_a;
  logic [NREG-1:0] dec_b;
  logic [NREG-1:0] iss_dec;
  logic [NREG-1:0] we_d;
  logic [NREG-1:0] sel_d;
  logic            collision_d;
  logic [NREG-1:0] pending_d;
  logic [NREG-1:0] pending_q;

  onehot_decd #(.ADDR_W(ADDR_W), .ZERO_MASK(ZERO_RO)) u_dec_a (
    .en   (wr_en_a),
    .addr (wr_addr_a),
    .dec  (dec_a)
  );

  onehot_decd #(.ADDR_W(ADDR_W), .ZERO_MASK(ZERO_RO)) u_dec_b (
    .en   (wr_en_b),
    .addr (wr_addr_b),
    .dec  (dec_b)
  );

  onehot_decd #(.ADDR_W(ADDR_W), .ZERO_MASK(ZERO_RO)) u_dec_iss (
    .en   (iss_en),
    .addr (iss_addr),
    .dec  (iss_dec)
  );

  // Port B's data wins a same-register write, so its decode is the select.
  always_comb begin
    we_d        = dec_a | dec_b;
    sel_d       = dec_b;
    collision_d = |(dec_a & dec_b);
    pending_d   = (pending_q & ~we_d) | iss_dec;
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending  = pending_q;
  assign rd_stall = pending_q[rd_addr_a] | pending_q[rd_addr_b];

  generate
    if (OUT_REG) begin : g_out_reg
      logic [NREG-1:0] we_q;
      logic [NREG-1:0] sel_q;
      logic            collision_q;

      always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
          we_q        <= '0;
          sel_q       <= '0;
          collision_q <= 1'b0;
        end else begin
          we_q        <= we_d;
          sel_q       <= sel_d;
          collision_q <= collision_d;
        end
      end

      assign we_onehot = we_q;
      assign sel_b     = sel_q;
      assign collision = collision_q;
    end else begin : g_out_comb
      assign we_onehot = we_d;
      assign sel_b     = sel_d;
      assign collision = collision_d;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Bench for regfile_wr_ctrl: registered 32-entry instance driven from a vector table,
// plus a combinational 8-entry instance swept over every A/B address pair.
module tb_regfile_wr_ctrl;

  localparam int AW  = 5;
  localparam int N   = 32;
  localparam int SAW = 3;
  localparam int SN  = 8;
  localparam int NROWS = 24;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          ea, eb, ie;
  logic [AW-1:0] aa, ab, ia, ra, rb;
  logic [N-1:0]  we, sel, pend;
  logic          col, stall;

  logic           s_ea, s_eb, s_ie;
  logic [SAW-1:0] s_aa, s_ab, s_ia, s_ra, s_rb;
  logic [SN-1:0]  s_we, s_sel, s_pend;
  logic           s_col, s_stall;

  regfile_wr_ctrl #(.ADDR_W(AW), .ZERO_RO(1'b1), .OUT_REG(1'b1)) dut (
    .clock(clk), .ctrl_reset_n(rst_n),
    .wr_en_a(ea), .wr_addr_a(aa), .wr_en_b(eb), .wr_addr_b(ab),
    .iss_en(ie), .iss_addr(ia), .rd_addr_a(ra), .rd_addr_b(rb),
    .we_onehot(we), .sel_b(sel), .collision(col), .pending(pend), .rd_stall(stall)
  );

  regfile_wr_ctrl #(.ADDR_W(SAW), .ZERO_RO(1'b1), .OUT_REG(1'b0)) dut_s (
    .clock(clk), .ctrl_reset_n(rst_n),
    .wr_en_a(s_ea), .wr_addr_a(s_aa), .wr_en_b(s_eb), .wr_addr_b(s_ab),
    .iss_en(s_ie), .iss_addr(s_ia), .rd_addr_a(s_ra), .rd_addr_b(s_rb),
    .we_onehot(s_we), .sel_b(s_sel), .collision(s_col), .pending(s_pend), .rd_stall(s_stall)
  );

  typedef struct {
    logic          ea;
    logic [AW-1:0] aa;
    logic          eb;
    logic [AW-1:0] ab;
    logic          ie;
    logic [AW-1:0] ia;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [31:0]   x_we;
    logic [31:0]   x_sel;
    logic          x_col;
    logic          x_stall;
    logic [31:0]   x_pend;
  } vec_t;

  typedef struct {
    logic [31:0] we;
    logic [31:0] sel;
    logic        col;
  } dexp_t;

  vec_t  tbl [NROWS];
  dexp_t sbq [$];
  int    n_pass  = 0;
  int    n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [31:0] b(input int i);
    return 32'd1 << i;
  endfunction

  function automatic vec_t mk(input int e_a, input int a_a, input int e_b, input int a_b,
                              input int i_e, input int i_a, input int r_a, input int r_b,
                              input logic [31:0] w, input logic [31:0] s, input int c,
                              input int st, input logic [31:0] p);
    vec_t v;
    v.ea = 1'(e_a);  v.aa = AW'(a_a);
    v.eb = 1'(e_b);  v.ab = AW'(a_b);
    v.ie = 1'(i_e);  v.ia = AW'(i_a);
    v.ra = AW'(r_a); v.rb = AW'(r_b);
    v.x_we = w; v.x_sel = s; v.x_col = 1'(c); v.x_stall = 1'(st); v.x_pend = p;
    return v;
  endfunction

  // Reference for the small instance: register 0 is never written.
  function automatic dexp_t sweep_model(input logic e_a, input int a, input logic e_b, input int bb);
    dexp_t r;
    r.we  = '0;
    r.sel = '0;
    for (int i = 1; i < SN; i++) begin
      if (e_a && a == i) r.we[i] = 1'b1;
      if (e_b && bb == i) begin
        r.we[i]  = 1'b1;
        r.sel[i] = 1'b1;
      end
    end
    r.col = e_a && e_b && (a == bb) && (a != 0);
    return r;
  endfunction

  task automatic drive_row(input vec_t v);
    ea = v.ea; aa = v.aa; eb = v.eb; ab = v.ab;
    ie = v.ie; ia = v.ia; ra = v.ra; rb = v.rb;
  endtask

  task automatic idle_main();
    ea = 1'b0; aa = '0; eb = 1'b0; ab = '0; ie = 1'b0; ia = '0; ra = '0; rb = '0;
  endtask

  task automatic idle_small();
    s_ea = 1'b0; s_aa = '0; s_eb = 1'b0; s_ab = '0; s_ie = 1'b0; s_ia = '0; s_ra = '0; s_rb = '0;
  endtask

  initial begin
    dexp_t d;
    dexp_t z;
    z.we = '0; z.sel = '0; z.col = 1'b0;

    // Decode fields describe this row's inputs (seen next cycle); stall/pend are seen this cycle.
    tbl[0]  = mk(1,31,0,0, 0,0, 0,0,  b(31), 0, 0, 0, 0);
    tbl[1]  = mk(0,0, 0,0, 0,0, 0,0,  0, 0, 0, 0, 0);
    tbl[2]  = mk(1,9, 1,9, 0,0, 0,0,  b(9), b(9), 1, 0, 0);
    tbl[3]  = mk(1,0, 1,0, 0,0, 0,0,  0, 0, 0, 0, 0);
    tbl[4]  = mk(1,3, 1,17,0,0, 0,0,  b(3)|b(17), b(17), 0, 0, 0);
    tbl[5]  = mk(0,0, 0,0, 1,12,12,0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0,0, 0,0, 0,0, 12,0, 0, 0, 0, 1, b(12));
    tbl[7]  = mk(0,0, 0,0, 0,0, 0,12, 0, 0, 0, 1, b(12));
    tbl[8]  = mk(1,12,0,0, 0,0, 12,0, b(12), 0, 0, 1, b(12));
    tbl[9]  = mk(0,0, 0,0, 0,0, 12,12,0, 0, 0, 0, 0);
    tbl[10] = mk(0,0, 0,0, 1,4, 0,4,  0, 0, 0, 0, 0);
    tbl[11] = mk(0,0, 1,4, 1,4, 0,4,  b(4), b(4), 0, 1, b(4));
    tbl[12] = mk(0,0, 0,0, 0,0, 0,4,  0, 0, 0, 1, b(4));
    tbl[13] = mk(1,4, 0,0, 0,0, 4,0,  b(4), 0, 0, 1, b(4));
    tbl[14] = mk(0,0, 0,0, 0,0, 4,4,  0, 0, 0, 0, 0);
    tbl[15] = mk(0,0, 0,0, 1,0, 0,0,  0, 0, 0, 0, 0);
    tbl[16] = mk(1,20,0,0, 0,0, 0,0,  b(20), 0, 0, 0, 0);
    tbl[17] = mk(0,0, 0,0, 0,0, 20,0, 0, 0, 0, 0, 0);
    tbl[18] = mk(1,2, 1,2, 1,2, 2,0,  b(2), b(2), 1, 0, 0);
    tbl[19] = mk(0,0, 0,0, 1,2, 2,0,  0, 0, 0, 1, b(2));
    tbl[20] = mk(0,0, 0,0, 1,5, 2,0,  0, 0, 0, 1, b(2));
    tbl[21] = mk(0,0, 1,2, 0,0, 2,5,  b(2), b(2), 0, 1, b(2)|b(5));
    tbl[22] = mk(1,5, 0,0, 0,0, 2,31, b(5), 0, 0, 0, b(5));
    tbl[23] = mk(0,0, 0,0, 0,0, 0,5,  0, 0, 0, 0, 0);

    // Reset with live inputs: nothing may leak through.
    rst_n = 1'b0;
    idle_main();
    idle_small();
    ea = 1'b1; aa = 5'd5; ie = 1'b1; ia = 5'd7; ra = 5'd7;
    s_ea = 1'b1; s_aa = 3'd5; s_ie = 1'b1; s_ia = 3'd7; s_ra = 3'd7;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_main();
    idle_small();
    ra = 5'd7;
    s_ra = 3'd7;
    @(negedge clk);
    chk("reset we_onehot", we, 32'd0);
    chk("reset sel_b", sel, 32'd0);
    chk("reset collision", 32'(col), 32'd0);
    chk("reset pending", pend, 32'd0);
    chk("reset rd_stall", 32'(stall), 32'd0);
    chk("reset small pending", 32'(s_pend), 32'd0);
    chk("reset small rd_stall", 32'(s_stall), 32'd0);
    sbq.push_back(z);

    for (int k = 0; k < NROWS; k++) begin
      @(posedge clk);
      #1;
      drive_row(tbl[k]);
      d.we = tbl[k].x_we; d.sel = tbl[k].x_sel; d.col = tbl[k].x_col;
      sbq.push_back(d);
      @(negedge clk);
      d = sbq.pop_front();
      chk($sformatf("row%0d we_onehot(prev)", k), we, d.we);
      chk($sformatf("row%0d sel_b(prev)", k), sel, d.sel);
      chk($sformatf("row%0d collision(prev)", k), 32'(col), 32'(d.col));
      chk($sformatf("row%0d rd_stall", k), 32'(stall), 32'(tbl[k].x_stall));
      chk($sformatf("row%0d pending", k), pend, tbl[k].x_pend);
    end

    @(posedge clk);
    #1;
    idle_main();
    @(negedge clk);
    d = sbq.pop_front();
    chk("flush we_onehot", we, d.we);
    chk("flush sel_b", sel, d.sel);
    chk("flush collision", 32'(col), 32'(d.col));
    chk("flush pending", pend, 32'd0);

    // Combinational instance: every A/B pair, enables random except forced on for equal addresses.
    for (int a = 0; a < SN; a++) begin
      for (int bb = 0; bb < SN; bb++) begin
        @(posedge clk);
        #1;
        s_aa = SAW'(a);
        s_ab = SAW'(bb);
        if (a == bb) begin
          s_ea = 1'b1;
          s_eb = 1'b1;
        end else begin
          s_ea = 1'($urandom_range(0, 1));
          s_eb = 1'($urandom_range(0, 1));
        end
        sbq.push_back(sweep_model(s_ea, a, s_eb, bb));
        @(negedge clk);
        d = sbq.pop_front();
        chk($sformatf("sweep a%0d b%0d we_onehot", a, bb), 32'(s_we), d.we);
        chk($sformatf("sweep a%0d b%0d sel_b", a, bb), 32'(s_sel), d.sel);
        chk($sformatf("sweep a%0d b%0d collision", a, bb), 32'(s_col), 32'(d.col));
      end
    end

    @(posedge clk);
    #1;
    idle_small();
    @(negedge clk);
    chk("sweep small pending", 32'(s_pend), 32'd0);
    chk("sweep small we_onehot idle", 32'(s_we), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
